mips_muldiv_unit: RTL
=====================

Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and executes MULT/MULTU/DIV/DIVU over multiple cycles. It holds the HI/LO architectural state for MFHI/MFLO/MTHI/MTLO. While an operation runs it raises busy, which the hazard logic uses to stall the pipeline.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >= 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
start  input  1  request from EX: execute op this cycle.
op  input  3  muldiv_op_t encoding (package).
a  input  WIDTH  rs operand / dividend / MTHI-MTLO data.
b  input  WIDTH  rt operand / divisor.
flush  input  1  abort the in-flight op (branch/exception squash).
busy  output  1  op in progress; pipeline stall request.
done  output  1  one-cycle pulse when HI/LO receive a result.
hi  output  WIDTH  HI register (MFHI source).
lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset has priority over flush and start. Reset mid-op discards the op.
- States:
  - IDLE: start with op in {MULT,MULTU,DIV,DIVU} latches the operands and goes to RUN with counter=0. busy=1 from the next cycle.
  - RUN: one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle, for WIDTH cycles. Counter reaches WIDTH-1, then the unit goes to FIX.
  - FIX: applies result signs and writes hi/lo at the edge leaving FIX, then returns to IDLE. done=1 during FIX; busy=0 from IDLE.
- Latency: busy is high for exactly WIDTH+1 cycles. New hi/lo are visible the cycle after done.
- Signed ops work on magnitudes:
  - Product sign = sign(a)^sign(b); the negation is applied to the 2*WIDTH product.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Results: MULT/MULTU give {hi,lo} = full 2*WIDTH product. DIV/DIVU give lo=quotient, hi=remainder.
- Divide by zero: lo=all-ones, hi=a. The full iteration count still runs; no exception is raised.
- Signed most-negative / -1: lo=most-negative, hi=0.
- MTHI/MTLO with start in IDLE: hi (or lo) = a at that edge. Single cycle, busy stays 0, done stays 0.
- MFHI/MFLO: no state change. The pipeline reads hi/lo directly and must stall while busy=1.
- start while busy=1 is ignored (no latch, no error). Hazard logic guarantees a stall.
- flush in RUN or FIX: return to IDLE next edge. hi/lo are unchanged, done is not asserted, busy=0 next cycle.
- flush with start in IDLE: flush wins and nothing is latched (includes MTHI/MTLO).
- Unused op codes are treated as NOP.

Optional Feature:
MIPS_MULDIV_FAST_MUL_EN:
- Defined: MULT/MULTU use a single-cycle WIDTH x WIDTH multiplier. IDLE goes to FIX directly, so busy lasts 1 cycle and done fires in that cycle. Divide is unchanged.
- Undefined: iterative multiply as above (WIDTH+1 cycles).

Decomposition:
- Package mips_pkg holds:
  - typedef enum logic[2:0] muldiv_op_t: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - typedef enum muldiv_state_t: IDLE, RUN, FIX.
- Sub-module muldiv_step: combinational one-iteration datapath. It takes the op class, partial remainder/product and divisor/multiplicand, and returns the next partial result. It is instantiated once in mips_muldiv_unit.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, done pulse once, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005 after 33 cycles.
- MTHI a=0x12345678, then MULT with flush at RUN cycle 10 -> hi=0x12345678 held, done never pulses, busy=0 next cycle.
- A second start during that MULT is ignored.
- reset low mid-DIV -> hi=lo=0, busy=0 next cycle.
- WIDTH=8 variant: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 busy cycles.
- With MIPS_MULDIV_FAST_MUL_EN: busy=1 for 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared op/state types and op-class helpers for the
// iterative multiply/divide unit (mips_muldiv_unit).
package mips_pkg;

   typedef enum logic [2:0] {
      NOP   = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      DIV   = 3'd3,
      DIVU  = 3'd4,
      MTHI  = 3'd5,
      MTLO  = 3'd6
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   // Ops that occupy the iterative datapath.
   function automatic logic op_is_arith(muldiv_op_t op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic op_is_div(muldiv_op_t op);
      return (op == DIV) || (op == DIVU);
   endfunction

   // Signed ops run on magnitudes and fix signs at the end.
   function automatic logic op_is_signed(muldiv_op_t op);
      return (op == MULT) || (op == DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Multiply: radix-2 shift-add on {hi,lo}, multiplier consumed from lo[0].
// Divide:   restoring subtract on {rem,quo}, dividend bits shifted out of quo.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opnd_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem1;
   logic [WIDTH:0] diff;

   // Next partial product / partial remainder for this iteration.
   always_comb begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
      rem1  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff  = rem1 - {1'b0, opnd_i};
      acc_o = acc_i;
      if (is_div_i) begin
         // diff[WIDTH] is the borrow: set means the divisor did not fit.
         if (!diff[WIDTH])
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         else
            acc_o = {rem1[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
         // The carry out of the add lands in the top bit after the shift.
         if (acc_i[0])
            acc_o = {sum, acc_i[WIDTH-1:1]};
         else
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO state.
// Optional macro MIPS_MULDIV_FAST_MUL_EN: single-cycle multiplier, multiply
// goes IDLE->FIX directly; divide stays iterative.
import mips_pkg::*;

module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   muldiv_state_t      st_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               is_div_q, neg_q, rneg_q, bzero_q;
   logic               busy_q, done_q;

   logic               sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   res_hi_d, res_lo_d;

   // Operand magnitudes for the unsigned core.
   always_comb begin
      sgn   = op_is_signed(op);
      mag_a = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b = (sgn && b[WIDTH-1]) ? -b : b;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_d)
   );

   // Sign fix-up and divide-by-zero override applied in FIX.
   always_comb begin
      prod     = neg_q ? -acc_q : acc_q;
      quo      = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      res_hi_d = prod[2*WIDTH-1:WIDTH];
      res_lo_d = prod[WIDTH-1:0];
      if (is_div_q) begin
         if (bzero_q) begin
            res_lo_d = '1;
            res_hi_d = a_q;
         end else begin
            res_lo_d = neg_q  ? -quo : quo;
            res_hi_d = rneg_q ? -rem : rem;
         end
      end
   end

   // Control FSM with registered busy/done and HI/LO update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q     <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         a_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         bzero_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (st_q)
            IDLE: begin
               if (start && !flush) begin
                  if (op == MTHI) hi_q <= a;
                  if (op == MTLO) lo_q <= a;
                  if (op_is_arith(op)) begin
                     // Multiply and divide share the same seed: {0, |a|}.
                     acc_q    <= {{WIDTH{1'b0}}, mag_a};
                     opnd_q   <= mag_b;
                     a_q      <= a;
                     cnt_q    <= '0;
                     is_div_q <= op_is_div(op);
                     neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_q   <= sgn & a[WIDTH-1];
                     bzero_q  <= (b == '0);
                     busy_q   <= 1'b1;
                     st_q     <= RUN;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                     if (!op_is_div(op)) begin
                        acc_q  <= (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
                        st_q   <= FIX;
                        done_q <= 1'b1;
                     end
`endif
                  end
               end
            end
            RUN: begin
               if (flush) begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     st_q   <= FIX;
                     done_q <= 1'b1;
                  end
               end
            end
            FIX: begin
               st_q   <= IDLE;
               busy_q <= 1'b0;
               if (!flush) begin
                  hi_q <= res_hi_d;
                  lo_q <= res_lo_d;
               end
            end
            default: begin
               st_q   <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   // A squash arriving during FIX cancels the write, so the pulse is masked.
   assign done = done_q & ~flush;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
